write_dest_pipe: RTL and testbench

WRITE_DEST_PIPE -- requirements
Module: write_dest_pipe

---
 rtl/write_dest_pipe_pkg.sv | 20 ++
 rtl/write_dest_pipe_stage.sv | 36 +++
 rtl/write_dest_pipe.sv | 123 ++++++++++++
 tb/tb_write_dest_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/write_dest_pipe_pkg.sv
// Shared definitions for the write-destination pipeline: destination-select
// encodings, the default link register and the parameter limits.
package write_dest_pipe_pkg;

  // Destination select carried by the issuing instruction.
  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_LINK = 2'd2,
    DST_NONE = 2'd3
  } reg_dst_e;

  // Register written by link-type instructions (e.g. jal).
  localparam int DEFAULT_LINK_REG = 31;

  // Supported pipeline depth range.
  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 8;

endpackage : write_dest_pipe_pkg

// File: rtl/write_dest_pipe_stage.sv
// One destination-tracking stage: a {valid, addr} flop pair with async reset
// and a synchronous clear used to squash the entry on flush.
module dest_stage_reg #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;

  // Capture the upstream entry each cycle; invalid entries carry addr 0 so a
  // stale address never lingers in an empty stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_valid <= i_valid;
      r_addr  <= i_valid ? i_addr : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;

endmodule : dest_stage_reg

// File: rtl/write_dest_pipe.sv
// Write-destination pipeline: tracks the destination register of each
// in-flight instruction for DEPTH stages, drives the register-file write port
// from the oldest stage and reports forwarding/hazard information for the
// instruction currently in decode. DEPTH must lie in 2..8.
module write_dest_pipe
  import write_dest_pipe_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = DEFAULT_LINK_REG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          rt,
  input  logic [ADDR_W-1:0]          rd,
  input  logic [1:0]                 reg_dst,
  input  logic                       reg_write,
  input  logic                       issue_valid,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          src_a,
  input  logic [ADDR_W-1:0]          src_b,
  output logic                       wb_en,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic                       hazard,
  output logic [$clog2(DEPTH+1)-1:0] fwd_a,
  output logic [$clog2(DEPTH+1)-1:0] fwd_b
);

  localparam int                FWD_W     = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  reg_dst_e                       w_dst_sel;
  logic [ADDR_W-1:0]              w_new_addr;
  logic                           w_new_valid;
  logic [DEPTH-1:0]               w_d_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]   w_d_addr;
  logic [DEPTH-1:0]               w_clr;
  logic [DEPTH-1:0]               w_stg_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]   w_stg_addr;
  logic [FWD_W-1:0]               w_fwd_a;
  logic [FWD_W-1:0]               w_fwd_b;

  // Youngest-match priority encoder: returns k where stage k-1 is the
  // youngest valid stage writing src, or 0 when nothing matches. Register 0
  // is hard-wired and never forwarded.
  function automatic logic [FWD_W-1:0] youngest_match(
    input logic [ADDR_W-1:0]            src,
    input logic [DEPTH-1:0]             v,
    input logic [DEPTH-1:0][ADDR_W-1:0] a
  );
    logic [FWD_W-1:0] k;
    k = '0;
    // Scan oldest to youngest so the youngest hit is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i] && (a[i] == src) && (src != '0)) begin
        k = FWD_W'(i + 1);
      end
    end
    return k;
  endfunction

  assign w_dst_sel = reg_dst_e'(reg_dst);

  // Select the destination address of the issuing instruction.
  always_comb begin
    w_new_addr = '0;
    case (w_dst_sel)
      DST_RT:   w_new_addr = rt;
      DST_RD:   w_new_addr = rd;
      DST_LINK: w_new_addr = LINK_ADDR;
      default:  w_new_addr = '0;
    endcase
  end

  // A new entry is tracked only for a real, unstalled register write to a
  // nonzero register; everything else enters stage 0 as a bubble.
  assign w_new_valid = issue_valid & reg_write & ~stall &
                       (w_dst_sel != DST_NONE) & (w_new_addr != '0);

  // Shift chain: stage 0 takes the new entry, stage i takes stage i-1. Flush
  // squashes every stage except the write-back stage, which still advances so
  // the instruction already past the flush point retires.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_d_valid[g] = w_new_valid;
      assign w_d_addr[g]  = w_new_addr;
    end else begin : g_body
      assign w_d_valid[g] = w_stg_valid[g-1];
      assign w_d_addr[g]  = w_stg_addr[g-1];
    end

    if (g == DEPTH - 1) begin : g_wb
      assign w_clr[g] = 1'b0;
    end else begin : g_flushable
      assign w_clr[g] = flush;
    end

    dest_stage_reg #(
      .ADDR_W (ADDR_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr[g]),
      .i_valid (w_d_valid[g]),
      .i_addr  (w_d_addr[g]),
      .o_valid (w_stg_valid[g]),
      .o_addr  (w_stg_addr[g])
    );
  end

  assign w_fwd_a = youngest_match(src_a, w_stg_valid, w_stg_addr);
  assign w_fwd_b = youngest_match(src_b, w_stg_valid, w_stg_addr);

  // Stage registers clear asynchronously, so every output below drops to 0
  // as soon as rst rises.
  assign wb_en   = w_stg_valid[DEPTH-1];
  assign wb_addr = wb_en ? w_stg_addr[DEPTH-1] : '0;
  assign fwd_a   = w_fwd_a;
  assign fwd_b   = w_fwd_b;
  assign hazard  = (w_fwd_a != '0) | (w_fwd_b != '0);

endmodule : write_dest_pipe

// File: tb/tb_write_dest_pipe.sv
// Directed bench for write_dest_pipe at DEPTH 3 (main), 2 and 5, all three
// sharing one stimulus stream. Inputs change and outputs are sampled around
// the falling edge; "cycle n" is the interval holding the n-th falling edge.
module tb_write_dest_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rt, rd, src_a, src_b;
  logic [1:0] reg_dst;
  logic       reg_write, issue_valid, stall, flush;

  logic       wb_en3, hazard3, wb_en2, hazard2, wb_en5, hazard5;
  logic [4:0] wb_addr3, wb_addr2, wb_addr5;
  logic [1:0] fwd_a3, fwd_b3, fwd_a2, fwd_b2;
  logic [2:0] fwd_a5, fwd_b5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  write_dest_pipe #(.ADDR_W(5), .DEPTH(3), .LINK_REG(31)) dut3 (
    .clk(clk), .rst(rst), .rt(rt), .rd(rd), .reg_dst(reg_dst),
    .reg_write(reg_write), .issue_valid(issue_valid), .stall(stall),
    .flush(flush), .src_a(src_a), .src_b(src_b), .wb_en(wb_en3),
    .wb_addr(wb_addr3), .hazard(hazard3), .fwd_a(fwd_a3), .fwd_b(fwd_b3));

  write_dest_pipe #(.ADDR_W(5), .DEPTH(2), .LINK_REG(31)) dut2 (
    .clk(clk), .rst(rst), .rt(rt), .rd(rd), .reg_dst(reg_dst),
    .reg_write(reg_write), .issue_valid(issue_valid), .stall(stall),
    .flush(flush), .src_a(src_a), .src_b(src_b), .wb_en(wb_en2),
    .wb_addr(wb_addr2), .hazard(hazard2), .fwd_a(fwd_a2), .fwd_b(fwd_b2));

  write_dest_pipe #(.ADDR_W(5), .DEPTH(5), .LINK_REG(31)) dut5 (
    .clk(clk), .rst(rst), .rt(rt), .rd(rd), .reg_dst(reg_dst),
    .reg_write(reg_write), .issue_valid(issue_valid), .stall(stall),
    .flush(flush), .src_a(src_a), .src_b(src_b), .wb_en(wb_en5),
    .wb_addr(wb_addr5), .hazard(hazard5), .fwd_a(fwd_a5), .fwd_b(fwd_b5));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_in();
    rt = '0; rd = '0; reg_dst = 2'd0; reg_write = 1'b0; issue_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; src_a = '0; src_b = '0;
  endtask

  task automatic drive(input logic iv, input logic rw, input logic [1:0] dst,
                       input logic [4:0] rt_v, input logic [4:0] rd_v,
                       input logic st, input logic fl);
    issue_valid = iv; reg_write = rw; reg_dst = dst; rt = rt_v; rd = rd_v;
    stall = st; flush = fl;
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    src_a = 5'd5;
    repeat (2) tick();
    #1;
    n_cmp++; if (wb_en3 !== 1'b0) begin n_bad++; $display("FAIL reset wb_en3 got=%b exp=0", wb_en3); end
    n_cmp++; if (wb_addr3 !== 5'd0) begin n_bad++; $display("FAIL reset wb_addr3 got=%0d exp=0", wb_addr3); end
    n_cmp++; if (hazard3 !== 1'b0) begin n_bad++; $display("FAIL reset hazard3 got=%b exp=0", hazard3); end
    n_cmp++; if (fwd_a3 !== 2'd0) begin n_bad++; $display("FAIL reset fwd_a3 got=%0d exp=0", fwd_a3); end
    n_cmp++; if (wb_en2 !== 1'b0) begin n_bad++; $display("FAIL reset wb_en2 got=%b exp=0", wb_en2); end
    n_cmp++; if (wb_en5 !== 1'b0) begin n_bad++; $display("FAIL reset wb_en5 got=%b exp=0", wb_en5); end
    tick();
    rst = 1'b0;
    clear_in();
  endtask

  task automatic test_basic();
    logic       e_en;
    logic [1:0] e_fwd;
    for (int c = 0; c < 7; c++) begin
      tick();
      clear_in();
      src_a = 5'd5;
      if (c == 0) drive(1'b1, 1'b1, 2'd1, 5'd6, 5'd5, 1'b0, 1'b0);
      #1;
      e_en  = (c == 3);
      e_fwd = (c >= 1 && c <= 3) ? 2'(c) : 2'd0;
      n_cmp++; if (wb_en3 !== e_en) begin n_bad++; $display("FAIL basic wb_en3 c=%0d got=%b exp=%b", c, wb_en3, e_en); end
      n_cmp++; if (wb_addr3 !== (e_en ? 5'd5 : 5'd0)) begin n_bad++; $display("FAIL basic wb_addr3 c=%0d got=%0d exp=%0d", c, wb_addr3, e_en ? 5 : 0); end
      n_cmp++; if (fwd_a3 !== e_fwd) begin n_bad++; $display("FAIL basic fwd_a3 c=%0d got=%0d exp=%0d", c, fwd_a3, e_fwd); end
      n_cmp++; if (hazard3 !== (e_fwd != 0)) begin n_bad++; $display("FAIL basic hazard3 c=%0d got=%b exp=%b", c, hazard3, e_fwd != 0); end
      n_cmp++; if (fwd_b3 !== 2'd0) begin n_bad++; $display("FAIL basic fwd_b3 c=%0d got=%0d exp=0", c, fwd_b3); end
      n_cmp++; if (wb_en2 !== (c == 2)) begin n_bad++; $display("FAIL basic wb_en2 c=%0d got=%b exp=%b", c, wb_en2, c == 2); end
      n_cmp++; if (wb_en5 !== (c == 5)) begin n_bad++; $display("FAIL basic wb_en5 c=%0d got=%b exp=%b", c, wb_en5, c == 5); end
    end
  endtask

  task automatic test_link();
    logic [1:0] e_fwd;
    for (int c = 0; c < 8; c++) begin
      tick();
      clear_in();
      src_a = 5'd31;
      case (c)
        0: drive(1'b1, 1'b1, 2'd2, 5'd3, 5'd4, 1'b0, 1'b0);
        1: drive(1'b1, 1'b1, 2'd0, 5'd0, 5'd8, 1'b0, 1'b0);
        2: drive(1'b1, 1'b1, 2'd3, 5'd6, 5'd6, 1'b0, 1'b0);
        3: drive(1'b1, 1'b0, 2'd1, 5'd6, 5'd6, 1'b0, 1'b0);
        default: ;
      endcase
      #1;
      e_fwd = (c >= 1 && c <= 3) ? 2'(c) : 2'd0;
      n_cmp++; if (wb_en3 !== (c == 3)) begin n_bad++; $display("FAIL link wb_en3 c=%0d got=%b exp=%b", c, wb_en3, c == 3); end
      n_cmp++; if (wb_addr3 !== ((c == 3) ? 5'd31 : 5'd0)) begin n_bad++; $display("FAIL link wb_addr3 c=%0d got=%0d", c, wb_addr3); end
      n_cmp++; if (fwd_a3 !== e_fwd) begin n_bad++; $display("FAIL link fwd_a3 c=%0d got=%0d exp=%0d", c, fwd_a3, e_fwd); end
      n_cmp++; if (wb_addr2 !== ((c == 2) ? 5'd31 : 5'd0)) begin n_bad++; $display("FAIL link wb_addr2 c=%0d got=%0d", c, wb_addr2); end
      n_cmp++; if (wb_en5 !== (c == 5)) begin n_bad++; $display("FAIL link wb_en5 c=%0d got=%b exp=%b", c, wb_en5, c == 5); end
    end
  endtask

  task automatic test_youngest();
    tick(); clear_in(); drive(1'b1, 1'b1, 2'd0, 5'd7, 5'd1, 1'b0, 1'b0);
    tick(); drive(1'b1, 1'b1, 2'd0, 5'd7, 5'd1, 1'b0, 1'b0);
    tick(); clear_in(); src_a = 5'd7; src_b = 5'd0; #1;
    n_cmp++; if (fwd_a3 !== 2'd1) begin n_bad++; $display("FAIL youngest fwd_a3 got=%0d exp=1", fwd_a3); end
    n_cmp++; if (hazard3 !== 1'b1) begin n_bad++; $display("FAIL youngest hazard3 got=%b exp=1", hazard3); end
    n_cmp++; if (fwd_b3 !== 2'd0) begin n_bad++; $display("FAIL youngest fwd_b3_zero got=%0d exp=0", fwd_b3); end
    n_cmp++; if (fwd_a5 !== 3'd1) begin n_bad++; $display("FAIL youngest fwd_a5 got=%0d exp=1", fwd_a5); end
    tick(); src_a = 5'd8; src_b = 5'd7; #1;
    n_cmp++; if (fwd_b3 !== 2'd2) begin n_bad++; $display("FAIL youngest fwd_b3_c3 got=%0d exp=2", fwd_b3); end
    n_cmp++; if (fwd_a3 !== 2'd0) begin n_bad++; $display("FAIL youngest fwd_a3_nomatch got=%0d exp=0", fwd_a3); end
    n_cmp++; if (hazard3 !== 1'b1) begin n_bad++; $display("FAIL youngest hazard3_b got=%b exp=1", hazard3); end
    n_cmp++; if (wb_addr3 !== 5'd7) begin n_bad++; $display("FAIL youngest wb_addr3_c3 got=%0d exp=7", wb_addr3); end
    tick(); #1;
    n_cmp++; if (fwd_b3 !== 2'd3) begin n_bad++; $display("FAIL youngest fwd_b3_c4 got=%0d exp=3", fwd_b3); end
    n_cmp++; if (wb_addr3 !== 5'd7) begin n_bad++; $display("FAIL youngest wb_addr3_c4 got=%0d exp=7", wb_addr3); end
    tick(); #1;
    n_cmp++; if (wb_en3 !== 1'b0) begin n_bad++; $display("FAIL youngest wb_en3_c5 got=%b exp=0", wb_en3); end
    n_cmp++; if (hazard3 !== 1'b0) begin n_bad++; $display("FAIL youngest hazard3_c5 got=%b exp=0", hazard3); end
  endtask

  task automatic test_flush();
    logic       e_en2;
    logic [4:0] e_addr2;
    for (int c = 0; c < 7; c++) begin
      tick();
      clear_in();
      case (c)
        0: drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd9, 1'b0, 1'b0);
        1: drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd10, 1'b0, 1'b0);
        2: drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd11, 1'b0, 1'b1);
        3: begin src_a = 5'd10; src_b = 5'd9; end
        default: ;
      endcase
      #1;
      // Depth 2: stage 0 holds r10 during the flush and is not squashed
      // away from the write-back stage, so r10 retires there in cycle 3.
      e_en2   = (c == 2) || (c == 3);
      e_addr2 = (c == 2) ? 5'd9 : ((c == 3) ? 5'd10 : 5'd0);
      n_cmp++; if (wb_en3 !== (c == 3)) begin n_bad++; $display("FAIL flush wb_en3 c=%0d got=%b exp=%b", c, wb_en3, c == 3); end
      n_cmp++; if (wb_addr3 !== ((c == 3) ? 5'd9 : 5'd0)) begin n_bad++; $display("FAIL flush wb_addr3 c=%0d got=%0d", c, wb_addr3); end
      n_cmp++; if (wb_en2 !== e_en2) begin n_bad++; $display("FAIL flush wb_en2 c=%0d got=%b exp=%b", c, wb_en2, e_en2); end
      n_cmp++; if (wb_addr2 !== e_addr2) begin n_bad++; $display("FAIL flush wb_addr2 c=%0d got=%0d exp=%0d", c, wb_addr2, e_addr2); end
      n_cmp++; if (wb_en5 !== 1'b0) begin n_bad++; $display("FAIL flush wb_en5 c=%0d got=%b exp=0", c, wb_en5); end
      if (c == 3) begin
        n_cmp++; if (fwd_a3 !== 2'd0) begin n_bad++; $display("FAIL flush fwd_a3_squashed got=%0d exp=0", fwd_a3); end
        n_cmp++; if (fwd_b3 !== 2'd3) begin n_bad++; $display("FAIL flush fwd_b3_wb got=%0d exp=3", fwd_b3); end
      end
    end
  endtask

  task automatic test_stall();
    logic [1:0] e_fwd;
    for (int c = 0; c < 9; c++) begin
      tick();
      clear_in();
      src_a = 5'd12;
      case (c)
        0: drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd12, 1'b0, 1'b0);
        1: drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd13, 1'b1, 1'b1);
        2: drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd15, 1'b1, 1'b0);
        3: drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd14, 1'b0, 1'b0);
        default: ;
      endcase
      #1;
      e_fwd = (c == 1) ? 2'd1 : 2'd0;
      n_cmp++; if (wb_en3 !== (c == 6)) begin n_bad++; $display("FAIL stall wb_en3 c=%0d got=%b exp=%b", c, wb_en3, c == 6); end
      n_cmp++; if (wb_addr3 !== ((c == 6) ? 5'd14 : 5'd0)) begin n_bad++; $display("FAIL stall wb_addr3 c=%0d got=%0d", c, wb_addr3); end
      n_cmp++; if (fwd_a3 !== e_fwd) begin n_bad++; $display("FAIL stall fwd_a3 c=%0d got=%0d exp=%0d", c, fwd_a3, e_fwd); end
      n_cmp++; if (wb_addr2 !== ((c == 2) ? 5'd12 : ((c == 5) ? 5'd14 : 5'd0))) begin n_bad++; $display("FAIL stall wb_addr2 c=%0d got=%0d", c, wb_addr2); end
      n_cmp++; if (wb_addr5 !== ((c == 8) ? 5'd14 : 5'd0)) begin n_bad++; $display("FAIL stall wb_addr5 c=%0d got=%0d", c, wb_addr5); end
    end
  endtask

  task automatic test_async_reset();
    tick(); clear_in(); drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd1, 1'b0, 1'b0);
    tick(); drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd2, 1'b0, 1'b0);
    tick(); drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd3, 1'b0, 1'b0);
    tick(); clear_in(); src_a = 5'd3; src_b = 5'd2; #1;
    n_cmp++; if (hazard3 !== 1'b1) begin n_bad++; $display("FAIL areset pre_hazard3 got=%b exp=1", hazard3); end
    n_cmp++; if (wb_addr3 !== 5'd1) begin n_bad++; $display("FAIL areset pre_wb_addr3 got=%0d exp=1", wb_addr3); end
    rst = 1'b1;
    #1;
    n_cmp++; if (wb_en3 !== 1'b0) begin n_bad++; $display("FAIL areset wb_en3 got=%b exp=0", wb_en3); end
    n_cmp++; if (wb_addr3 !== 5'd0) begin n_bad++; $display("FAIL areset wb_addr3 got=%0d exp=0", wb_addr3); end
    n_cmp++; if (hazard3 !== 1'b0) begin n_bad++; $display("FAIL areset hazard3 got=%b exp=0", hazard3); end
    n_cmp++; if (fwd_a3 !== 2'd0) begin n_bad++; $display("FAIL areset fwd_a3 got=%0d exp=0", fwd_a3); end
    n_cmp++; if (fwd_b3 !== 2'd0) begin n_bad++; $display("FAIL areset fwd_b3 got=%0d exp=0", fwd_b3); end
    n_cmp++; if (wb_en2 !== 1'b0) begin n_bad++; $display("FAIL areset wb_en2 got=%b exp=0", wb_en2); end
    n_cmp++; if (hazard2 !== 1'b0) begin n_bad++; $display("FAIL areset hazard2 got=%b exp=0", hazard2); end
    n_cmp++; if (fwd_b2 !== 2'd0) begin n_bad++; $display("FAIL areset fwd_b2 got=%0d exp=0", fwd_b2); end
    n_cmp++; if (hazard5 !== 1'b0) begin n_bad++; $display("FAIL areset hazard5 got=%b exp=0", hazard5); end
    n_cmp++; if (fwd_a5 !== 3'd0) begin n_bad++; $display("FAIL areset fwd_a5 got=%0d exp=0", fwd_a5); end
    tick();
    // Release reset and issue in the same cycle: the first rising edge with
    // rst low must accept the instruction.
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      clear_in();
      if (c == 0) drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd20, 1'b0, 1'b0);
      #1;
      n_cmp++; if (wb_addr3 !== ((c == 3) ? 5'd20 : 5'd0)) begin n_bad++; $display("FAIL areset post_wb_addr3 c=%0d got=%0d", c, wb_addr3); end
      n_cmp++; if (wb_en2 !== (c == 2)) begin n_bad++; $display("FAIL areset post_wb_en2 c=%0d got=%b exp=%b", c, wb_en2, c == 2); end
      n_cmp++; if (wb_addr5 !== ((c == 5) ? 5'd20 : 5'd0)) begin n_bad++; $display("FAIL areset post_wb_addr5 c=%0d got=%0d", c, wb_addr5); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_in();
    rst = 1'b1;
    test_reset();
    idle(2);
    test_basic();
    idle(6);
    test_link();
    idle(6);
    test_youngest();
    idle(6);
    test_flush();
    idle(6);
    test_stall();
    idle(6);
    test_async_reset();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_write_dest_pipe
